// File: rtl/adc_axil_regfile.sv
// AXI4-Lite register file for the ADC capture path: control, status, overrange counters,
// scratch and ID registers. One outstanding write, one outstanding read, single clock domain.
module adc_axil_regfile #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] ID_VALUE   = 32'hAD964300,
    parameter int          TAP_WIDTH  = 5
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  adc_ready,
    input  logic                  adc_or_a,
    input  logic                  adc_or_b,
    output logic                  ctrl_enable,
    output logic                  ctrl_test_pat,
    output logic [TAP_WIDTH-1:0]  ctrl_delay_tap,
    output logic                  ctrl_delay_load
);
    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, holds its payload stable until that edge.

    localparam logic [2:0] SLOT_CTRL    = 3'd0;
    localparam logic [2:0] SLOT_STATUS  = 3'd1;
    localparam logic [2:0] SLOT_CNT_A   = 3'd2;
    localparam logic [2:0] SLOT_CNT_B   = 3'd3;
    localparam logic [2:0] SLOT_SCRATCH = 3'd4;
    localparam logic [2:0] SLOT_ID      = 3'd5;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    logic        aw_held, w_held;
    logic [2:0]  aw_slot_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [2:0]  wr_slot;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_ctrl, wr_scratch, wr_unmapped, clr_ovr;
    logic [31:0] scratch, scratch_next;
    logic [31:0] ovr_cnt_a, ovr_cnt_b;
    logic        sticky_a, sticky_b;
    logic [31:0] ctrl_word, rd_word;
    logic [2:0]  rd_slot;
    logic        rd_unmapped;
    logic        unused_inputs;

    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = ~aw_held;
    assign s_axi_wready  = ~w_held;
    assign s_axi_arready = ~s_axi_rvalid;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // Both held flags stay set while B is pending, so the bvalid term blocks a second commit.
    assign commit  = (aw_held | aw_hs) & (w_held | w_hs) & ~s_axi_bvalid;
    assign wr_slot = aw_held ? aw_slot_q : s_axi_awaddr[4:2];
    assign wr_data = w_held ? w_data_q : s_axi_wdata;
    assign wr_strb = w_held ? w_strb_q : s_axi_wstrb;

    assign wr_ctrl     = commit & (wr_slot == SLOT_CTRL);
    assign wr_scratch  = commit & (wr_slot == SLOT_SCRATCH);
    assign wr_unmapped = (wr_slot[2:1] == 2'b11);
    assign clr_ovr     = wr_ctrl & wr_strb[0] & wr_data[2];

    always_comb begin
        scratch_next = scratch;
        for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) scratch_next[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_slot_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_slot_q <= s_axi_awaddr[4:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_unmapped ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ctrl_enable     <= 1'b0;
            ctrl_test_pat   <= 1'b0;
            ctrl_delay_tap  <= '0;
            ctrl_delay_load <= 1'b0;
            scratch         <= '0;
        end else begin
            ctrl_delay_load <= wr_ctrl & wr_strb[1];
            if (wr_ctrl && wr_strb[0]) begin
                ctrl_enable   <= wr_data[0];
                ctrl_test_pat <= wr_data[1];
            end
            if (wr_ctrl && wr_strb[1]) ctrl_delay_tap <= wr_data[8 +: TAP_WIDTH];
            if (wr_scratch) scratch <= scratch_next;
        end
    end

    // A clear on the same edge as a pulse wins; counters stop at all-ones.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ovr_cnt_a <= '0;
            ovr_cnt_b <= '0;
            sticky_a  <= 1'b0;
            sticky_b  <= 1'b0;
        end else if (clr_ovr) begin
            ovr_cnt_a <= '0;
            ovr_cnt_b <= '0;
            sticky_a  <= 1'b0;
            sticky_b  <= 1'b0;
        end else begin
            if (adc_or_a) begin
                sticky_a <= 1'b1;
                if (ovr_cnt_a != 32'hFFFF_FFFF) ovr_cnt_a <= ovr_cnt_a + 32'd1;
            end
            if (adc_or_b) begin
                sticky_b <= 1'b1;
                if (ovr_cnt_b != 32'hFFFF_FFFF) ovr_cnt_b <= ovr_cnt_b + 32'd1;
            end
        end
    end

    always_comb begin
        ctrl_word                  = '0;
        ctrl_word[0]               = ctrl_enable;
        ctrl_word[1]               = ctrl_test_pat;
        ctrl_word[8 +: TAP_WIDTH]  = ctrl_delay_tap;
    end

    always_comb begin
        rd_slot     = s_axi_araddr[4:2];
        rd_word     = '0;
        rd_unmapped = 1'b0;
        case (rd_slot)
            SLOT_CTRL:    rd_word = ctrl_word;
            SLOT_STATUS:  rd_word = {29'd0, sticky_b, sticky_a, adc_ready};
            SLOT_CNT_A:   rd_word = ovr_cnt_a;
            SLOT_CNT_B:   rd_word = ovr_cnt_b;
            SLOT_SCRATCH: rd_word = scratch;
            SLOT_ID:      rd_word = ID_VALUE;
            default:      rd_unmapped = 1'b1;
        endcase
    end

    // Read data is sampled from the pre-edge register values, so a write committing
    // on the same edge is not visible to this read.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
            s_axi_rresp  <= rd_unmapped ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_axil_regfile.sv
// Directed bench for adc_axil_regfile: table of register accesses plus hand-written
// sequences for write ordering, B backpressure, overrange counting/clearing and reset abort.
module tb_adc_axil_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        adc_ready, adc_or_a, adc_or_b;
    logic        ctrl_enable, ctrl_test_pat, ctrl_delay_load;
    logic [4:0]  ctrl_delay_tap;

    int n_checks = 0;
    int n_pass   = 0;
    int load_cnt = 0;

    typedef struct packed {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    adc_axil_regfile dut (
        .s_axi_aclk      (clk),
        .s_axi_aresetn   (rst_n),
        .s_axi_awaddr    (awaddr),
        .s_axi_awprot    (awprot),
        .s_axi_awvalid   (awvalid),
        .s_axi_awready   (awready),
        .s_axi_wdata     (wdata),
        .s_axi_wstrb     (wstrb),
        .s_axi_wvalid    (wvalid),
        .s_axi_wready    (wready),
        .s_axi_bresp     (bresp),
        .s_axi_bvalid    (bvalid),
        .s_axi_bready    (bready),
        .s_axi_araddr    (araddr),
        .s_axi_arprot    (arprot),
        .s_axi_arvalid   (arvalid),
        .s_axi_arready   (arready),
        .s_axi_rdata     (rdata),
        .s_axi_rresp     (rresp),
        .s_axi_rvalid    (rvalid),
        .s_axi_rready    (rready),
        .adc_ready       (adc_ready),
        .adc_or_a        (adc_or_a),
        .adc_or_b        (adc_or_b),
        .ctrl_enable     (ctrl_enable),
        .ctrl_test_pat   (ctrl_test_pat),
        .ctrl_delay_tap  (ctrl_delay_tap),
        .ctrl_delay_load (ctrl_delay_load)
    );

    // Each high sample of the load strobe counts once, so a stretched pulse shows up as extra counts.
    always @(negedge clk) if (ctrl_delay_load === 1'b1) load_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timeout waiting for handshake (got none, expected one within bound)", name);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_ok, w_ok, aw_fire, w_fire;
        int cyc;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        aw_ok = 1'b0; w_ok = 1'b0; cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) begin awvalid = 1'b0; aw_ok = 1'b1; end
            if (w_fire)  begin wvalid = 1'b0; w_ok = 1'b1; end
            cyc++;
        end
        if (!(aw_ok && w_ok)) begin
            awvalid = 1'b0; wvalid = 1'b0;
            timeout_fail("write_addr_data");
        end
        cyc = 0;
        while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
        resp = bresp;
        if (!bvalid) timeout_fail("write_resp");
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
        if (!arready) timeout_fail("read_addr");
        @(negedge clk);
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
        data = rdata;
        resp = rresp;
        if (!rvalid) timeout_fail("read_data");
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic pulse_or(input logic chan_b);
        @(negedge clk);
        if (chan_b) adc_or_b = 1'b1; else adc_or_a = 1'b1;
        @(negedge clk);
        adc_or_a = 1'b0; adc_or_b = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;

        vecs.push_back('{1'b1, 5'h00, 32'h0123_4561, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0501});
        vecs.push_back('{1'b1, 5'h00, 32'h89AB_CDE2, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 5'h04, 32'h0,         4'h0, 2'b00, 32'h0000_0001});
        vecs.push_back('{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'h0000_0D02});
        vecs.push_back('{1'b0, 5'h14, 32'h0,         4'h0, 2'b00, 32'hAD96_4300});
        vecs.push_back('{1'b0, 5'h18, 32'h0,         4'h0, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 5'h1C, 32'h0,         4'h0, 2'b10, 32'h0});
        vecs.push_back('{1'b1, 5'h10, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 5'h10, 32'h0,         4'h0, 2'b00, 32'h00BB_00DD});
        vecs.push_back('{1'b1, 5'h14, 32'h1234_5678, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 5'h14, 32'h0,         4'h0, 2'b00, 32'hAD96_4300});
        vecs.push_back('{1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0});
        vecs.push_back('{1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0});
        vecs.push_back('{1'b1, 5'h10, 32'hFFFF_FFFF, 4'hA, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 5'h10, 32'h0,         4'h0, 2'b00, 32'hFFBB_FFDD});
        vecs.push_back('{1'b0, 5'h08, 32'h0,         4'h0, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 5'h0C, 32'h0000_0007, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 5'h0C, 32'h0,         4'h0, 2'b00, 32'h0});

        // Clock/reset
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        adc_ready = 1'b1; adc_or_a = 1'b0; adc_or_b = 1'b0;
        repeat (3) @(negedge clk);
        check32("rst_ready", {29'd0, awready, wready, arready}, 32'h7);
        check32("rst_valid", {30'd0, bvalid, rvalid}, 32'h0);
        check32("rst_resp_data", {bresp, rresp, rdata[27:0]}, 32'h0);
        check32("rst_ctrl", {25'd0, ctrl_delay_tap, ctrl_test_pat, ctrl_enable}, 32'h0);
        check32("rst_load", {31'd0, ctrl_delay_load}, 32'h0);
        rst_n = 1'b1;

        // Table-driven accesses
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check32($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
                if (i == 0) begin
                    check32("w1_enable", {31'd0, ctrl_enable}, 32'h1);
                    check32("w1_tap", {27'd0, ctrl_delay_tap}, 32'h5);
                    check32("w1_load_pulses", load_cnt, 32'd1);
                end
            end else begin
                axi_read(vecs[i].addr, data, resp);
                check32($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
                check32($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
            end
        end
        check32("ctrl_outputs", {25'd0, ctrl_delay_tap, ctrl_test_pat, ctrl_enable}, {25'd0, 5'hD, 1'b1, 1'b0});
        check32("load_pulses", load_cnt, 32'd2);

        // W three cycles ahead of AW, then B held off for five cycles
        @(negedge clk);
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        check32("early_w_ready", {30'd0, awready, wready}, 32'h2);
        check32("early_w_no_b", {31'd0, bvalid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        awaddr = 5'h10; awvalid = 1'b1;
        @(negedge clk);
        check32("late_aw_commit", {29'd0, bvalid, awready, wready}, 32'h4);
        awaddr = 5'h10; wdata = 32'h5566_7788; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check32($sformatf("bhold_c%0d", c), {27'd0, bvalid, awready, wready, bresp}, 32'h10);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check32("after_b_ready", {29'd0, bvalid, awready, wready}, 32'h3);
        axi_read(5'h10, data, resp);
        check32("single_commit", data, 32'h1122_3344);

        // Overrange on B, then clear coincident with a pulse
        pulse_or(1'b1);
        pulse_or(1'b1);
        pulse_or(1'b1);
        axi_read(5'h0C, data, resp);
        check32("cnt_b_3", data, 32'd3);
        axi_read(5'h04, data, resp);
        check32("status_b", data, 32'h5);
        @(negedge clk);
        awaddr = 5'h00; wdata = 32'h0000_0004; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b1; adc_or_b = 1'b1;
        @(negedge clk);
        adc_or_b = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check32("clr_bvalid", {31'd0, bvalid}, 32'h1);
        @(negedge clk);
        bready = 1'b0;
        axi_read(5'h0C, data, resp);
        check32("cnt_b_cleared", data, 32'h0);
        axi_read(5'h04, data, resp);
        check32("status_cleared", data, 32'h1);
        axi_read(5'h00, data, resp);
        check32("ctrl_clr_reads0", data, 32'h0000_0D00);

        // Saturation on A from a preloaded near-full count
        @(negedge clk);
        force dut.ovr_cnt_a = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.ovr_cnt_a;
        pulse_or(1'b0);
        pulse_or(1'b0);
        pulse_or(1'b0);
        axi_read(5'h08, data, resp);
        check32("cnt_a_sat", data, 32'hFFFF_FFFF);
        axi_read(5'h04, data, resp);
        check32("status_a", data, 32'h3);

        // Reset while a read response is pending
        axi_write(5'h00, 32'h0000_0001, 4'h1, resp);
        @(negedge clk);
        araddr = 5'h00; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        check32("pend_r_valid", {31'd0, rvalid}, 32'h1);
        check32("pend_r_data", rdata, 32'h0000_0D01);
        #2 rst_n = 1'b0;
        #1;
        check32("rst_abort_r", {29'd0, rvalid, arready, ctrl_enable}, 32'h2);
        check32("rst_abort_tap", {27'd0, ctrl_delay_tap}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(5'h00, data, resp);
        check32("ctrl_after_rst", data, 32'h0);
        axi_read(5'h08, data, resp);
        check32("cnt_a_after_rst", data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
